// File: rtl/rot_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rot_arbiter
// Description : Two-requester round-robin arbiter feeding a single 4-bit
//               rotate unit with a one-entry result register. The winner's
//               operand is rotated left or right by 0..3 and held until the
//               consumer takes it.
//               Optional grant counters are built when ROT_ARB_GNT_COUNT_EN
//               is defined. Without it, gnt_cnt0/gnt_cnt1 are tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module rot_arbiter #(
  parameter logic RR_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [3:0] req0_data,
  input  logic [1:0] req0_amt,
  input  logic       req0_dir,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [3:0] req1_data,
  input  logic [1:0] req1_amt,
  input  logic       req1_dir,
  output logic       req1_ready,
  output logic       out_valid,
  output logic [3:0] out_data,
  output logic       out_id,
  input  logic       out_ready,
  output logic [7:0] gnt_cnt0,
  output logic [7:0] gnt_cnt1
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic       ptr_q, ptr_d;
  logic       out_valid_q, out_valid_d;
  logic [3:0] out_data_q, out_data_d;
  logic       out_id_q, out_id_d;

  logic       gnt_w;     // requester granted this cycle (meaningful in IDLE)
  logic       fire_w;    // a transfer happens on the next edge
  logic [3:0] rot_w;     // rotated operand of the granted requester

  // Circular 4-bit rotate. A right rotate by k is a left rotate by (4-k) mod 4.
  function automatic logic [3:0] rotate4(input logic [3:0] d,
                                         input logic [1:0] amt,
                                         input logic       dir);
    logic [1:0] lamt;
    logic [3:0] r;
    lamt = dir ? (2'd0 - amt) : amt;
    case (lamt)
      2'd0:    r = d;
      2'd1:    r = {d[2:0], d[3]};
      2'd2:    r = {d[1:0], d[3:2]};
      default: r = {d[0], d[3:1]};
    endcase
    return r;
  endfunction

  // Grant selection: a lone valid requester wins, otherwise the pointer decides.
  always_comb begin
    gnt_w = ptr_q;
    if (req0_valid && !req1_valid) begin
      gnt_w = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      gnt_w = 1'b1;
    end
  end

  // Rotate the operand of whichever requester currently holds the grant.
  always_comb begin
    rot_w = gnt_w ? rotate4(req1_data, req1_amt, req1_dir)
                  : rotate4(req0_data, req0_amt, req0_dir);
  end

  // Next-state and handshake outputs; requesters are never ready while full.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    fire_w      = 1'b0;
    case (state_q)
      IDLE: begin
        req0_ready = (gnt_w == 1'b0);
        req1_ready = (gnt_w == 1'b1);
        fire_w     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
        if (fire_w) begin
          state_d     = HOLD;
          ptr_d       = ~gnt_w;
          out_valid_d = 1'b1;
          out_data_d  = rot_w;
          out_id_d    = gnt_w;
        end
      end
      HOLD: begin
        // Consuming the result only frees the slot; no new accept this cycle.
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State, pointer and result register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= RR_INIT;
      out_valid_q <= 1'b0;
      out_data_q  <= 4'd0;
      out_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

`ifdef ROT_ARB_GNT_COUNT_EN
  logic [7:0] gnt_cnt0_q, gnt_cnt0_d;
  logic [7:0] gnt_cnt1_q, gnt_cnt1_d;

  // Saturating per-requester grant counters, stepped on each transfer.
  always_comb begin
    gnt_cnt0_d = gnt_cnt0_q;
    gnt_cnt1_d = gnt_cnt1_q;
    if (fire_w && !gnt_w && gnt_cnt0_q != 8'hFF) begin
      gnt_cnt0_d = gnt_cnt0_q + 8'd1;
    end
    if (fire_w && gnt_w && gnt_cnt1_q != 8'hFF) begin
      gnt_cnt1_d = gnt_cnt1_q + 8'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt0_q <= 8'd0;
      gnt_cnt1_q <= 8'd0;
    end else begin
      gnt_cnt0_q <= gnt_cnt0_d;
      gnt_cnt1_q <= gnt_cnt1_d;
    end
  end

  assign gnt_cnt0 = gnt_cnt0_q;
  assign gnt_cnt1 = gnt_cnt1_q;
`else
  assign gnt_cnt0 = 8'd0;
  assign gnt_cnt1 = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rot_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rot_arbiter
// Description : Directed self-checking bench for rot_arbiter (RR_INIT = 0).
//               Counter expectations follow ROT_ARB_GNT_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rot_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic [3:0] req0_data, req1_data;
  logic [1:0] req0_amt, req1_amt;
  logic       req0_dir, req1_dir;
  logic       req0_ready, req1_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_id;
  logic       out_ready;
  logic [7:0] gnt_cnt0, gnt_cnt1;

  int n_checks;
  int n_errors;

  rot_arbiter #(.RR_INIT(1'b0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_amt   (req0_amt),
    .req0_dir   (req0_dir),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_amt   (req1_amt),
    .req1_dir   (req1_dir),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_id     (out_id),
    .out_ready  (out_ready),
    .gnt_cnt0   (gnt_cnt0),
    .gnt_cnt1   (gnt_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] v_data [3];
  logic [1:0] v_amt  [3];
  logic       v_dir  [3];
  logic [3:0] v_exp  [3];
  logic       rr_id  [4];
  logic [7:0] exp_cnt0;

  initial begin
    n_checks = 0;
    n_errors = 0;
    v_data[0] = 4'b1001; v_amt[0] = 2'd1; v_dir[0] = 1'b1; v_exp[0] = 4'b1100;
    v_data[1] = 4'b0110; v_amt[1] = 2'd2; v_dir[1] = 1'b1; v_exp[1] = 4'b1001;
    v_data[2] = 4'b1001; v_amt[2] = 2'd3; v_dir[2] = 1'b0; v_exp[2] = 4'b1100;
    rr_id[0] = 1'b0; rr_id[1] = 1'b1; rr_id[2] = 1'b0; rr_id[3] = 1'b1;

    rst_n = 1'b0;
    req0_valid = 1'b0; req0_data = 4'd0; req0_amt = 2'd0; req0_dir = 1'b0;
    req1_valid = 1'b0; req1_data = 4'd0; req1_amt = 2'd0; req1_dir = 1'b0;
    out_ready = 1'b0;

    // Reset state
    #1;
    check_val("rst_out_valid", {7'd0, out_valid}, 8'd0);
    check_val("rst_out_data", {4'd0, out_data}, 8'd0);
    check_val("rst_out_id", {7'd0, out_id}, 8'd0);
    check_val("rst_cnt0", gnt_cnt0, 8'd0);
    check_val("rst_cnt1", gnt_cnt1, 8'd0);
    #11;
    rst_n = 1'b1;
    #1;
    check_val("idle_ready0_ptr0", {7'd0, req0_ready}, 8'd1);
    check_val("idle_ready1_ptr0", {7'd0, req1_ready}, 8'd0);

    // req0 only: 1001 rotl 1 -> 0011
    req0_valid = 1'b1; req0_data = 4'b1001; req0_amt = 2'd1; req0_dir = 1'b0;
    #1;
    check_val("r0_ready_pre", {7'd0, req0_ready}, 8'd1);
    tick();
    req0_valid = 1'b0;
    check_val("r0_out_valid", {7'd0, out_valid}, 8'd1);
    check_val("r0_out_data", {4'd0, out_data}, 8'h3);
    check_val("r0_out_id", {7'd0, out_id}, 8'd0);
    check_val("r0_hold_ready0", {7'd0, req0_ready}, 8'd0);
    check_val("r0_hold_ready1", {7'd0, req1_ready}, 8'd0);
    out_ready = 1'b1;
    tick();
    check_val("r0_consumed", {7'd0, out_valid}, 8'd0);
    check_val("ptr1_ready1", {7'd0, req1_ready}, 8'd1);
    check_val("ptr1_ready0", {7'd0, req0_ready}, 8'd0);
    tick();
    check_val("idle_ptr_stable", {7'd0, req1_ready}, 8'd1);

    // req1 only: three rotate vectors
    for (int i = 0; i < 3; i++) begin
      req1_valid = 1'b1; req1_data = v_data[i]; req1_amt = v_amt[i]; req1_dir = v_dir[i];
      tick();
      check_val($sformatf("r1_v%0d_valid", i), {7'd0, out_valid}, 8'd1);
      check_val($sformatf("r1_v%0d_data", i), {4'd0, out_data}, {4'd0, v_exp[i]});
      check_val($sformatf("r1_v%0d_id", i), {7'd0, out_id}, 8'd1);
      tick();
      check_val($sformatf("r1_v%0d_gap", i), {7'd0, out_valid}, 8'd0);
    end
    req1_valid = 1'b0;

    // Both valid continuously, pointer at 0: ids 0,1,0,1 with one-cycle gaps
    req0_valid = 1'b1; req0_data = 4'b0001; req0_amt = 2'd0; req0_dir = 1'b0;
    req1_valid = 1'b1; req1_data = 4'b1000; req1_amt = 2'd0; req1_dir = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val($sformatf("rr%0d_valid", i), {7'd0, out_valid}, 8'd1);
      check_val($sformatf("rr%0d_id", i), {7'd0, out_id}, {7'd0, rr_id[i]});
      check_val($sformatf("rr%0d_data", i), {4'd0, out_data}, rr_id[i] ? 8'h8 : 8'h1);
      tick();
      check_val($sformatf("rr%0d_gap", i), {7'd0, out_valid}, 8'd0);
    end
    req1_valid = 1'b0;

    // Backpressure: result 0101 rotr 1 -> 1010 held for 5 cycles
    out_ready = 1'b0;
    req0_data = 4'b0101; req0_amt = 2'd1; req0_dir = 1'b1;
    tick();
    check_val("bp_valid", {7'd0, out_valid}, 8'd1);
    check_val("bp_data0", {4'd0, out_data}, 8'hA);
    req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req0_data = ~req0_data;
      req0_amt  = req0_amt + 2'd1;
      tick();
      check_val($sformatf("bp%0d_data", i), {4'd0, out_data}, 8'hA);
      check_val($sformatf("bp%0d_valid", i), {7'd0, out_valid}, 8'd1);
      check_val($sformatf("bp%0d_rdy", i), {6'd0, req0_ready, req1_ready}, 8'd0);
    end
    out_ready = 1'b1;
    tick();
    check_val("bp_release", {7'd0, out_valid}, 8'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    check_val("bp_ptr1", {7'd0, req1_ready}, 8'd1);

    // Async reset in HOLD: req1 wins, pointer -> 0 ... use req0 so pointer -> 1
    out_ready = 1'b0;
    req0_valid = 1'b1; req0_data = 4'b1111; req0_amt = 2'd2; req0_dir = 1'b0;
    // pointer is 1 but only req0 valid, so req0 wins and pointer goes to 1
    tick();
    req0_valid = 1'b0;
    check_val("ar_hold_valid", {7'd0, out_valid}, 8'd1);
    check_val("ar_hold_ptr1", {7'd0, req1_ready}, 8'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("ar_valid", {7'd0, out_valid}, 8'd0);
    check_val("ar_data", {4'd0, out_data}, 8'd0);
    check_val("ar_ptr_init", {7'd0, req0_ready}, 8'd1);
    #2;
    rst_n = 1'b1;
    tick();
    check_val("ar_after_edge", {7'd0, out_valid}, 8'd0);

    // 300 grants to req0, counters saturate when enabled
    out_ready = 1'b1;
    req0_valid = 1'b1; req0_data = 4'b0010; req0_amt = 2'd3; req0_dir = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      tick();
    end
    req0_valid = 1'b0;
    check_val("sat_last_id", {7'd0, out_id}, 8'd0);
    check_val("sat_last_data", {4'd0, out_data}, 8'h4);
`ifdef ROT_ARB_GNT_COUNT_EN
    exp_cnt0 = 8'd255;
`else
    exp_cnt0 = 8'd0;
`endif
    check_val("sat_cnt0", gnt_cnt0, exp_cnt0);
    check_val("sat_cnt1", gnt_cnt1, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
